// File: rtl/tone_counter_bank.sv
// Bank of CHANNELS preload-counter square-wave voices sharing one prescaler, mixed to a saturated signed 16-bit sample.
// Optional per-voice 4-bit volume register is enabled by defining TONE_VOLUME_EN.
module tone_counter_bank #(
   parameter int CHANNELS = 2,
   parameter int CNT_W    = 8,
   parameter int PRESCALE = 96,
   parameter int AMP      = 18000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                pause,
   input  logic                wr,
`ifdef TONE_VOLUME_EN
   input  logic                wr_vol,
`endif
   input  logic [1:0]          wr_chan,
   input  logic [CNT_W-1:0]    wr_data,
   output logic [CHANNELS-1:0] tick_out,
   output logic [15:0]         audio
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]    PLAST   = PW'(PRESCALE - 1);
   localparam logic [PW-1:0]    PONE    = PW'(1);
   localparam logic [CNT_W-1:0] ONES    = '1;
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] ONES_M1 = ONES - ONE;

   logic [PW-1:0] presc_reg;
   logic          tick;

   assign tick = (presc_reg == PLAST) && !pause;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_reg <= '0;
      end else if (!pause) begin
         presc_reg <= (presc_reg == PLAST) ? '0 : presc_reg + PONE;
      end
   end

   logic signed [17:0] contrib [CHANNELS];

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_voice
         logic [CNT_W-1:0]   preload_reg;
         logic [CNT_W-1:0]   count_reg;
         logic               toggle_reg;
         logic               tick_reg;
         logic               wr_hit;
         logic               preload_wr;
         logic signed [17:0] mag;

         // Writes to a voice index beyond CHANNELS never match any voice.
         assign wr_hit = wr && (wr_chan == 2'(gi));

`ifdef TONE_VOLUME_EN
         logic [3:0]  vol_reg;
         logic [31:0] scaled;

         assign preload_wr = wr_hit && !wr_vol;
         assign scaled     = 32'(AMP) * {27'd0, ({1'b0, vol_reg} + 5'd1)};
         assign mag        = 18'(scaled >> 4);

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               vol_reg <= 4'hF;
            end else if (wr_hit && wr_vol) begin
               vol_reg <= wr_data[3:0];
            end
         end
`else
         assign preload_wr = wr_hit;
         assign mag        = 18'(AMP);
`endif

         // The reload reads preload_reg before this edge's write lands.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               preload_reg <= ONES;
               count_reg   <= ONES;
               toggle_reg  <= 1'b0;
               tick_reg    <= 1'b0;
            end else begin
               if (preload_wr) begin
                  preload_reg <= wr_data;
               end
               tick_reg <= tick && (count_reg == ONES_M1);
               if (tick) begin
                  count_reg <= (count_reg == ONES) ? preload_reg : count_reg + ONE;
                  if (count_reg == ONES_M1) begin
                     toggle_reg <= ~toggle_reg;
                  end
               end
            end
         end

         assign tick_out[gi] = tick_reg;
         assign contrib[gi]  = (count_reg == ONES) ? 18'sd0 : (toggle_reg ? mag : -mag);
      end
   endgenerate

   logic signed [17:0] sum;
   logic [15:0]        audio_next;
   logic [15:0]        audio_reg;

   always_comb begin
      sum = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         sum = sum + contrib[i];
      end
      if (sum > 18'sd32767) begin
         audio_next = 16'h7FFF;
      end else if (sum < -18'sd32768) begin
         audio_next = 16'h8000;
      end else begin
         audio_next = sum[15:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         audio_reg <= '0;
      end else if (!pause) begin
         audio_reg <= audio_next;
      end
   end

   assign audio = audio_reg;

endmodule

// File: tb/tb_tone_counter_bank.sv
// Self-checking bench for tone_counter_bank: directed tables, hand sequences and random stimulus vs. a reference model.
// Two instances (AMP=1000 and AMP=20000) share all inputs so saturation is observed alongside the normal mix.
module tb_tone_counter_bank;

   localparam int CH   = 2;
   localparam int CW   = 8;
   localparam int PS   = 4;
   localparam int AMP1 = 1000;
   localparam int AMP2 = 20000;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       pause = 1'b0;
   logic       wr = 1'b0;
   logic       wr_vol = 1'b0;
   logic [1:0] wr_chan = 2'd0;
   logic [7:0] wr_data = 8'd0;
   logic [1:0]  tick_a, tick_b;
   logic [15:0] audio_a, audio_b;

   always #5 clk = ~clk;

   tone_counter_bank #(.CHANNELS(CH), .CNT_W(CW), .PRESCALE(PS), .AMP(AMP1)) dut_a (
      .clk(clk), .reset(reset), .pause(pause), .wr(wr),
`ifdef TONE_VOLUME_EN
      .wr_vol(wr_vol),
`endif
      .wr_chan(wr_chan), .wr_data(wr_data), .tick_out(tick_a), .audio(audio_a));

   tone_counter_bank #(.CHANNELS(CH), .CNT_W(CW), .PRESCALE(PS), .AMP(AMP2)) dut_b (
      .clk(clk), .reset(reset), .pause(pause), .wr(wr),
`ifdef TONE_VOLUME_EN
      .wr_vol(wr_vol),
`endif
      .wr_chan(wr_chan), .wr_data(wr_data), .tick_out(tick_b), .audio(audio_b));

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: integer state per voice following the tone rules.
   int m_presc;
   int m_cnt [CH];
   int m_pre [CH];
   bit m_tog [CH];
   bit m_tick [CH];
   int m_audio_a, m_audio_b;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int mix(input int amp);
      int s = 0;
      for (int i = 0; i < CH; i++) begin
         if (m_cnt[i] != 255) s += m_tog[i] ? amp : -amp;
      end
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return s;
   endfunction

   task automatic model_reset();
      m_presc = 0;
      m_audio_a = 0;
      m_audio_b = 0;
      for (int i = 0; i < CH; i++) begin
         m_cnt[i] = 255; m_pre[i] = 255; m_tog[i] = 0; m_tick[i] = 0;
      end
   endtask

   task automatic model_edge(input bit p, input bit w, input int ch, input int d);
      bit tk;
      int mix_a, mix_b;
      mix_a = mix(AMP1);
      mix_b = mix(AMP2);
      tk = (m_presc == PS - 1) && !p;
      if (!p) begin
         m_audio_a = mix_a;
         m_audio_b = mix_b;
      end
      for (int i = 0; i < CH; i++) begin
         m_tick[i] = tk && (m_cnt[i] == 254);
         if (tk) begin
            if (m_cnt[i] == 254) m_tog[i] = !m_tog[i];
            m_cnt[i] = (m_cnt[i] == 255) ? m_pre[i] : m_cnt[i] + 1;
         end
      end
      if (w && ch < CH) m_pre[ch] = d;
      if (!p) m_presc = (m_presc + 1) % PS;
   endtask

   task automatic cycle(input bit p, input bit w, input int ch, input int d);
      pause = p; wr = w; wr_chan = ch[1:0]; wr_data = d[7:0];
      @(posedge clk);
      model_edge(p, w, ch, d);
      #1;
      check("audio_a", int'($signed(audio_a)), m_audio_a);
      check("audio_b", int'($signed(audio_b)), m_audio_b);
      check("tick_a", int'(tick_a), int'({m_tick[1], m_tick[0]}));
      check("tick_b", int'(tick_b), int'({m_tick[1], m_tick[0]}));
      wr = 1'b0; pause = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
   endtask

   task automatic wait_pulse(input int ch, input int budget, output int waited, output bit found);
      found = 0;
      waited = 0;
      while (!found && waited < budget) begin
         cycle(0, 0, 0, 0);
         waited++;
         if (tick_a[ch]) found = 1;
      end
   endtask

   task automatic async_reset();
      #2 reset = 1'b1;
      #1;
      model_reset();
      check("rst_audio_a", int'($signed(audio_a)), 0);
      check("rst_audio_b", int'($signed(audio_b)), 0);
      check("rst_tick", int'({tick_b, tick_a}), 0);
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   typedef struct {
      int chan;
      int data;
      int interval;
   } vec_t;

   vec_t vecs [7];
   int   pat [4];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int  w, bad, iv;
      bit  f, seen_pos, seen_neg;
      int  held_a, held_b;

      vecs[0] = '{0, 'hFE, 8};
      vecs[1] = '{0, 'hF8, 32};
      vecs[2] = '{1, 'hFC, 16};
      vecs[3] = '{1, 'hC0, 256};
      vecs[4] = '{0, 'h80, 512};
      vecs[5] = '{1, 'hFF, 0};
      vecs[6] = '{0, 'hFF, 0};
      pat = '{-1000, 0, 1000, 0};

      // Power-on reset
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      check("por_audio", int'($signed(audio_a)), 0);
      check("por_tick", int'({tick_b, tick_a}), 0);
      reset = 1'b0;

      // Silent without writes
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         cycle(0, 0, 0, 0);
         if (audio_a != 16'd0 || audio_b != 16'd0 || tick_a != 2'd0) bad++;
      end
      check("t1_silent", bad, 0);

      // ch0 = 0xFE: -1000, 0, +1000, 0 each held 4 clk
      cycle(0, 1, 0, 'hFE);
      f = 0;
      for (int i = 0; i < 40 && !f; i++) begin
         cycle(0, 0, 0, 0);
         if ($signed(audio_a) == -16'sd1000) f = 1;
      end
      check("t2_sync", int'(f), 1);
      for (int k = 0; k < 16; k++) begin
         if (k > 0) cycle(0, 0, 0, 0);
         check("t2_audio", int'($signed(audio_a)), pat[(k / 4) % 4]);
         check("t2_tick", int'(tick_a[0]), int'(k % 8 == 3));
      end

      // Async reset while sounding, then silent
      idle(3);
      async_reset();
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         cycle(0, 0, 0, 0);
         if (audio_a != 16'd0 || tick_a != 2'd0) bad++;
      end
      check("t6_silent", bad, 0);

      // Table: preload -> toggle-pulse interval in clk
      foreach (vecs[r]) begin
         cycle(0, 1, vecs[r].chan, vecs[r].data);
         if (vecs[r].interval == 0) begin
            idle(1100);
            wait_pulse(vecs[r].chan, 600, w, f);
            check("tbl_silent", int'(f), 0);
         end else begin
            wait_pulse(vecs[r].chan, 3000, w, f);
            wait_pulse(vecs[r].chan, 3000, w, f);
            wait_pulse(vecs[r].chan, 3000, iv, f);
            check("tbl_interval", f ? iv : -1, vecs[r].interval);
         end
      end

      // Write 0x80 on the same edge as the reload that loads 0xFE
      cycle(0, 1, 0, 'hFE);
      f = 0;
      for (int i = 0; i < 1200 && !f; i++) begin
         if (m_presc == PS - 1 && m_cnt[0] == 255) f = 1;
         else cycle(0, 0, 0, 0);
      end
      check("t4_sync", int'(f), 1);
      cycle(0, 1, 0, 'h80);
      wait_pulse(0, 3000, w, f);
      check("t4_first", f ? w : -1, 4);
      wait_pulse(0, 3000, w, f);
      check("t4_second", f ? w : -1, 512);

      // Saturation: both voices at 0xFE in lock-step
      async_reset();
      cycle(0, 1, 0, 'hFE);
      cycle(0, 1, 1, 'hFE);
      bad = 0; seen_pos = 0; seen_neg = 0;
      for (int i = 0; i < 40; i++) begin
         cycle(0, 0, 0, 0);
         if ($signed(audio_b) == 16'sd32767) seen_pos = 1;
         else if ($signed(audio_b) == -16'sd32768) seen_neg = 1;
         else if (audio_b != 16'd0) bad++;
      end
      check("t3_pos", int'(seen_pos), 1);
      check("t3_neg", int'(seen_neg), 1);
      check("t3_nowrap", bad, 0);

      // Pause mid-tone with an ignored write to voice 3
      idle(5);
      held_a = int'($signed(audio_a));
      held_b = int'($signed(audio_b));
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         cycle(1, i == 20, 3, 'h10);
         if (int'($signed(audio_a)) != held_a || int'($signed(audio_b)) != held_b || tick_a != 2'd0) bad++;
      end
      check("t5_frozen", bad, 0);
      wait_pulse(0, 100, w, f);
      wait_pulse(0, 100, w, f);
      check("t5_resume", f ? w : -1, 8);

      // Random writes and pauses against the model
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom % 8) == 0, ($urandom % 16) == 0, int'($urandom % 4),
               ($urandom % 4 == 0) ? int'($urandom % 256) : int'(8'hF0 + $urandom % 16));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tone_counter_bank.md
Name: tone_counter_bank

Overview:
- Parametrised successor of the single-channel discrete tone circuit (free-running clock, preloadable 8-bit up-counter, /2 toggle stage).
- Provides CHANNELS independent preload-counter square-wave voices, each with a CPU-writable preload register.
- Voices share one internal prescaler that replaces the 555 timer. Their outputs are mixed into one saturated signed 16-bit sample.
- Sits between the CPU OUT-port decode and the audio low-pass filter/mixer.

Parameters:
- CHANNELS, 2: number of voices, 1..4.
- CNT_W, 8: counter and preload width in bits.
- PRESCALE, 96: clk cycles per counter tick. Must be >= 2.
- AMP, 18000: per-voice output magnitude, signed 16-bit.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- pause  in  1  freezes prescaler, counters and toggles; audio holds its last value.
- wr  in  1  one-cycle preload write strobe.
- wr_chan  in  2  target voice for wr.
- wr_data  in  CNT_W  preload value.
- tick_out  out  CHANNELS  one-cycle pulse per voice on each toggle.
- audio  out  16  signed mixed sample, registered.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high. All registers clear immediately on reset assertion, no clk edge needed.
- Reset values:
  - prescaler = 0.
  - every preload = all-ones. Every count = all-ones. Every toggle = 0.
  - tick_out = 0. audio = 0.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps to 0.
  - tick asserts for one cycle when prescaler == PRESCALE-1 and !pause.
  - While pause is high the prescaler holds.
- Per voice, on tick:
  - If count == all-ones: count <= preload (reload).
  - Otherwise: count <= count+1.
  - If count == all-ones-1: toggle flips and tick_out[i] pulses for exactly one cycle.
- Tick period is 2^CNT_W − preload ticks. Square-wave period is 2·(2^CNT_W − preload)·PRESCALE clk cycles.
- Preload = all-ones: count stays at all-ones, so the voice is permanently silent and never pulses.
- Writes:
  - wr=1 with wr_chan < CHANNELS: preload[wr_chan] <= wr_data on the next edge.
  - wr_chan >= CHANNELS: write is ignored.
  - Writes are accepted during pause.
  - If a write and a reload happen in the same cycle, the reload uses the old preload; the new value applies at the next reload.
  - A write never disturbs the current count or toggle.
- Voice contribution:
  - 0 when count == all-ones (one silent tick per period).
  - Otherwise +AMP if toggle=1, −AMP if toggle=0.
- Mix:
  - Sum all contributions at 18-bit signed width.
  - Saturate to [−32768, 32767].
  - Register into audio, 1-cycle latency from the count/toggle state.
  - audio does not update while pause=1.
- Reset asserted mid-tone: all outputs return to reset values immediately. After release the voice stays silent until a write.

Optional Feature:
- Macro: TONE_VOLUME_EN.
- When defined:
  - Adds input port wr_vol (1).
  - A wr with wr_vol=1 writes wr_data[3:0] into a per-voice 4-bit volume register instead of preload. Volume resets to 15.
  - Magnitude = (AMP·(vol+1))>>4, computed with at least 21-bit intermediate width.
- When undefined: no wr_vol port; magnitude is always AMP.

Test Plan:
All tests use CHANNELS=2, CNT_W=8, PRESCALE=4, AMP=1000 unless noted.
1. Reset and release with no writes for 1000 clk -> audio = 0 and tick_out = 0 throughout.
2. Write ch0 = 0xFE -> audio repeats −1000, 0, +1000, 0, each value held 4 clk. tick_out[0] pulses every 8 clk.
3. AMP=20000; write ch0 = 0xFE and ch1 = 0xFE in consecutive cycles before the first reload -> audio reaches +32767 and −32768 (saturated), never wraps.
4. Write ch0 = 0x80 in the same cycle as its reload from 0xFE -> the next period is still 2 ticks; the period after that is 128 ticks.
5. pause=1 for 50 clk mid-tone -> audio, tick_out and counters frozen; after release the sequence resumes exactly where it stopped. A write to wr_chan=3 has no effect.
6. Assert reset asynchronously between clk edges while ch0 is sounding -> audio = 0 before the next edge; silent after release.
